// File: rtl/ytydla_cmac_pkg.sv
// Shared types and defaults for the CMAC accumulator slice.
// Data width comes from the global YTYDLA_DATA_LENGTH define (16 if none is provided).
`ifndef YTYDLA_DATA_LENGTH
`define YTYDLA_DATA_LENGTH 16
`endif

package ytydla_cmac_pkg;
   localparam int DATA_W    = `YTYDLA_DATA_LENGTH;
   localparam int ACC_W_DEF = 32;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } cmac_state_e;
endpackage

// File: rtl/ytydla_cmac_sat.sv
// Clamps a wide two's-complement accumulator into the signed DATA_W result range.
module ytydla_cmac_sat
   import ytydla_cmac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc_in,
   output logic [DATA_W-1:0] sat_out,
   output logic              clip
);
   // The value fits iff every bit from the result sign bit upward agrees.
   logic [ACC_W-DATA_W:0] hi;
   logic                  fits;

   assign hi   = acc_in[ACC_W-1:DATA_W-1];
   assign fits = (&hi) | ~(|hi);

   always_comb begin
      clip    = ~fits;
      sat_out = acc_in[DATA_W-1:0];
      if (!fits)
         sat_out = acc_in[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
   end
endmodule

// File: rtl/ytydla_cmac_acc.sv
// Dot-product accumulator: bias + cfg_len products, saturated result with valid/ready.
// Optional macro YTYDLA_CMAC_ACC_RELU_EN zeroes negative results before registering.
module ytydla_cmac_acc
   import ytydla_cmac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic signed [DATA_W-1:0] bias,
   input  logic                     prod_valid,
   input  logic signed [DATA_W-1:0] prod,
   output logic                     prod_ready,
   output logic                     res_valid,
   output logic signed [DATA_W-1:0] res_data,
   input  logic                     res_ready,
   output logic                     busy,
   output logic                     sat_flag
);
   cmac_state_e       state, state_nxt;
   logic [ACC_W-1:0]  acc, acc_nxt;
   logic [LEN_W-1:0]  cnt, cnt_nxt;
   logic [ACC_W-1:0]  bias_ext, prod_ext;
   logic [DATA_W-1:0] sat_val, res_val;
   logic              clip, load_res;

   assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
   assign prod_ext = {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: if (start) begin
            acc_nxt   = bias_ext;
            cnt_nxt   = cfg_len;
            state_nxt = (cfg_len != '0) ? ST_ACC : ST_OUT;
         end
         ST_ACC: if (prod_valid) begin
            acc_nxt = acc + prod_ext;
            cnt_nxt = cnt - 1'b1;
            if (cnt == LEN_W'(1))
               state_nxt = ST_OUT;
         end
         ST_OUT: if (res_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Saturate the value acc is about to take so the result registers on entry to OUT.
   ytydla_cmac_sat #(.ACC_W(ACC_W)) u_sat (
      .acc_in  (acc_nxt),
      .sat_out (sat_val),
      .clip    (clip)
   );

`ifdef YTYDLA_CMAC_ACC_RELU_EN
   assign res_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
   assign res_val = sat_val;
`endif

   assign load_res = (state_nxt == ST_OUT) && (state != ST_OUT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         cnt      <= '0;
         res_data <= '0;
         sat_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         if (load_res) begin
            res_data <= res_val;
            sat_flag <= clip;
         end
      end
   end

   assign prod_ready = (state == ST_ACC);
   assign res_valid  = (state == ST_OUT);
   assign busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_ytydla_cmac_acc.sv
// Randomized scoreboard bench for ytydla_cmac_acc with directed corner cases.
`ifndef YTYDLA_DATA_LENGTH
`define YTYDLA_DATA_LENGTH 16
`endif

module tb_ytydla_cmac_acc;
   localparam int N = `YTYDLA_DATA_LENGTH;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [7:0]          cfg_len = '0;
   logic signed [N-1:0] bias = '0;
   logic                prod_valid = 1'b0;
   logic signed [N-1:0] prod = '0;
   logic                prod_ready, res_valid, busy, sat_flag;
   logic signed [N-1:0] res_data;
   logic                res_ready = 1'b1;

   int total = 0;
   int bad   = 0;
   logic [N:0] sb[$];
   int pq[$];

   ytydla_cmac_acc #(.ACC_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .bias(bias),
      .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact integer sum, 32-bit wrap, clamp to N-bit signed range.
   function automatic logic [N:0] model(input int b);
      longint s = b;
      int     a;
      int     d;
      logic   c;
      foreach (pq[i]) s += pq[i];
      a = int'(s);
      c = 1'b0;
      d = a;
      if (a > 32767)  begin d = 32767;  c = 1'b1; end
      if (a < -32768) begin d = -32768; c = 1'b1; end
`ifdef YTYDLA_CMAC_ACC_RELU_EN
      if (d < 0) d = 0;
`endif
      return {c, d[N-1:0]};
   endfunction

   // Monitor: every completed output handshake pops one expected result.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            logic [N:0] e;
            e = sb.pop_front();
            chk("res_data", longint'(res_data), longint'($signed(e[N-1:0])));
            chk("sat_flag", longint'(sat_flag), longint'(e[N]));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // Runs one operation using pq as products; abort_after>=0 resets mid-stream.
   task automatic run_op(input int len, input int b, input bit gaps, input int abort_after);
      int p;
      wait_idle();
      start = 1'b1; cfg_len = 8'(len); bias = N'(b);
      sb.push_back(model(b));
      @(posedge clk); #1;
      start = 1'b0; cfg_len = 8'($urandom); bias = N'($urandom);
      if (len == 0) begin
         @(negedge clk);
         chk("zero_len_valid", res_valid, 1);
         chk("zero_len_no_ready", prod_ready, 0);
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (i == abort_after) begin
            void'(sb.pop_back());
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("rst_prod_ready", prod_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_sat_flag", sat_flag, 0);
            rst_n = 1'b1;
            return;
         end
         if (gaps) repeat ($urandom_range(0, 2)) begin
            prod_valid = 1'b0; prod = N'($urandom);
            @(posedge clk); #1;
         end
         p = pq[i];
         prod_valid = 1'b1; prod = N'(p);
         @(negedge clk);
         chk("prod_ready", prod_ready, 1);
         @(posedge clk); #1;
      end
      prod_valid = 1'b0;
      @(negedge clk);
      chk("latency_valid", res_valid, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, b, mode;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_prod_ready", prod_ready, 0);
      chk("reset_res_data", res_data, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic accumulation, overflow, negative result, zero length.
      pq = '{1, 2, 3};        run_op(3, 10, 0, -1);
      pq = '{32767, 32767};   run_op(2, 0, 0, -1);
      pq = '{-3};             run_op(1, -5, 0, -1);
      pq = '{};               run_op(0, 7, 0, -1);
      pq = '{-32768, -32768}; run_op(2, -1, 1, -1);

      // Backpressure: result must hold and start must be ignored.
      wait_idle();
      res_ready = 1'b0;
      pq = '{1}; run_op(1, 100, 0, -1);
      for (int i = 0; i < 5; i++) begin
         start = i[0]; cfg_len = 8'd0; bias = 16'sd55;
         @(negedge clk);
         chk("bp_res_data", res_data, 101);
         chk("bp_res_valid", res_valid, 1);
         chk("bp_prod_ready", prod_ready, 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_handshake_idle", busy, 0);

      // Reset mid-operation, then a fresh operation.
      pq = '{100, 200, 300, 400}; run_op(4, 9, 0, 2);
      pq = '{4}; run_op(1, 0, 0, -1);

      // Random operations.
      for (int t = 0; t < 40; t++) begin
         len  = $urandom_range(0, 6);
         b    = $signed(16'($urandom));
         mode = $urandom_range(0, 2);
         pq   = {};
         for (int i = 0; i < len; i++) begin
            if (mode == 0)      pq.push_back($urandom_range(20000, 32767));
            else if (mode == 1) pq.push_back(-int'($urandom_range(20000, 32768)));
            else                pq.push_back($signed(16'($urandom)));
         end
         run_op(len, b, 1, -1);
      end

      wait_idle();
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ytydla_cmac_acc.md
YTYDLA_CMAC_ACC -- requirements
Module: ytydla_cmac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 32: accumulator width in bits; must be at least `YTYDLA_DATA_LENGTH + LEN_W.
REQ-002 SHALL have parameter LEN_W, default 8: width of the products-per-result count.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: begin a new dot product; latches cfg_len and bias.
REQ-006 SHALL have port cfg_len, input, LEN_W: number of products accumulated per result.
REQ-007 SHALL have port bias, input, `YTYDLA_DATA_LENGTH, signed: initial accumulator value, fixed-point format identical to products.
REQ-008 SHALL have port prod_valid, input, 1: product present from the multiplier stage.
REQ-009 SHALL have port prod, input, `YTYDLA_DATA_LENGTH, signed: product, already shifted by `YTYDLA_DATA_DOTPOT.
REQ-010 SHALL have port prod_ready, output, 1: block accepts prod this cycle.
REQ-011 SHALL have port res_valid, output, 1: result available.
REQ-012 SHALL have port res_data, output, `YTYDLA_DATA_LENGTH, signed: saturated result.
REQ-013 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.
REQ-015 SHALL have port sat_flag, output, 1: the current result was clipped; qualified by res_valid.

Function
REQ-016 SHALL implement the FSM states IDLE, ACC and OUT.
- prod_ready = (state==ACC).
- res_valid = (state==OUT).
- busy = (state!=IDLE).
REQ-017 In IDLE, start=1 SHALL load acc with sign-extended bias and load cnt with cfg_len; next state is ACC if cfg_len!=0, otherwise OUT.
REQ-018 In ACC, each cycle with prod_valid=1 SHALL add sign-extended prod to acc and decrement cnt; when the accepted product has cnt==1, next state is OUT.
REQ-019 Cycles in ACC with prod_valid=0 SHALL leave acc and cnt unchanged; there is no timeout.
REQ-020 On entering OUT, res_data and sat_flag SHALL be registered from the final acc value, so the result is valid exactly 1 cycle after the last product is accepted, or 1 cycle after start when cfg_len==0.
REQ-021 In OUT, res_data and sat_flag SHALL remain stable until res_valid && res_ready; on that handshake, next state is IDLE.
REQ-022 start SHALL be ignored outside IDLE; a start in the same cycle as the OUT handshake is also ignored.
REQ-023 acc SHALL wrap modulo 2^ACC_W with no internal saturation.
REQ-024 The output SHALL saturate to [-2^(N-1), 2^(N-1)-1], where N=`YTYDLA_DATA_LENGTH; sat_flag=1 when clipping occurred.
REQ-025 cfg_len and bias SHALL be sampled only at start; later changes have no effect on the running operation.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set:
- state=IDLE;
- acc, cnt, res_data and sat_flag to 0;
- hence prod_ready=0, res_valid=0, busy=0.
REQ-027 Reset mid-operation SHALL discard the partial sum; the first start after reset SHALL behave as from power-up.

Configuration
REQ-028 With macro YTYDLA_CMAC_ACC_RELU_EN defined, a negative saturated result SHALL be replaced by 0 before it is registered into res_data.
- sat_flag still reflects clipping only.
- Without the macro, the signed saturated value passes through unchanged.

Structure
REQ-029 Package ytydla_cmac_pkg SHALL hold:
- the FSM state enum type;
- the default ACC_W and LEN_W constants.
REQ-030 Saturation logic SHALL be a combinational sub-module ytydla_cmac_sat (ACC_W in, `YTYDLA_DATA_LENGTH out plus clip flag), instantiated once.

Verification (N=16)
REQ-031 Basic accumulation: start with cfg_len=3, bias=10; products 1, 2, 3 on consecutive cycles -> res_valid one cycle after the third accept, res_data=16, sat_flag=0.
REQ-032 Positive overflow: cfg_len=2, bias=0; products 32767, 32767 -> res_data=32767, sat_flag=1.
REQ-033 Negative result: cfg_len=1, bias=-5; product -3 -> res_data=-8 (0 with RELU_EN), sat_flag=0.
REQ-034 Backpressure: hold res_ready=0 for 5 cycles and pulse start during that time -> res_data stable, prod_ready=0, start ignored; handshake on cycle 6 -> IDLE.
REQ-035 Reset mid-operation: assert rst_n=0 for 1 cycle after 2 of 4 products -> all outputs 0 at next edge; a new start with cfg_len=1, bias=0 and product 4 -> res_data=4.
REQ-036 Zero length: cfg_len=0, bias=7 -> res_valid the cycle after start, res_data=7, no prod_ready asserted.
